// File: rtl/mm_pkg.sv
// Shared definitions for the matrix feeder: controller states and lane-slicing helpers.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Lowest bit of lane `lane` in a packed bus of d_w-wide lanes.
  function automatic int lane_lo(input int lane, input int d_w);
    return lane * d_w;
  endfunction

  function automatic int lane_hi(input int lane, input int d_w);
    return lane * d_w + d_w - 1;
  endfunction

endpackage

// File: rtl/pipe.sv
// Fixed-length delay line: out_data is in_data delayed by `pipes` clock cycles, cleared by rst.
module pipe #(
  parameter int D_W   = 8,
  parameter int pipes = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D_W-1:0] in_data,
  output logic [D_W-1:0] out_data
);

  logic [D_W-1:0] stage [pipes];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < pipes; j++) begin
        stage[j] <= '0;
      end
    end else begin
      stage[0] <= in_data;
      for (int unsigned j = 1; j < pipes; j++) begin
        stage[j] <= stage[j-1];
      end
    end
  end

  assign out_data = stage[pipes-1];

endmodule

// File: rtl/matrix_feeder.sv
// Reads M columns of N elements from memory and feeds them to a systolic array,
// skewing lane i by i cycles and tagging every element with a per-lane valid.
module matrix_feeder
  import mm_pkg::*;
#(
  parameter int D_W = 8,
  parameter int N   = 4,
  parameter int M   = 16,
  parameter int A_W = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [A_W-1:0]   rd_addr,
  input  logic [N*D_W-1:0] rd_data,
  output logic [N*D_W-1:0] out_data,
  output logic [N-1:0]     out_valid
);

  localparam int C_W = $clog2(N + 1);
  localparam logic [A_W-1:0] LAST_ADDR  = A_W'(M - 1);
  localparam logic [C_W-1:0] LAST_DRAIN = C_W'(N);

  state_t state, state_nxt;

  logic [A_W-1:0]   addr;
  logic [C_W-1:0]   drain_cnt;
  logic             rd_en_q;
  logic             cap_valid;
  logic [N*D_W-1:0] cap_data;
  logic [D_W:0]     lane_out [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // done is registered, so it pulses the cycle after DONE while the FSM already
  // sits in IDLE; start is held off during that pulse to keep jobs from overlapping.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !done) state_nxt = READ;
      READ:    if (addr == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == LAST_DRAIN) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (state == READ);
    busy    = (state != IDLE);
    rd_addr = addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      addr      <= (state == READ && state_nxt == READ) ? addr + 1'b1 : '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      done      <= (state == DONE);
    end
  end

  // Memory answers one cycle after rd_en; anything arriving without that flag is zeroed here.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q   <= 1'b0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else begin
      rd_en_q   <= rd_en;
      cap_valid <= rd_en_q;
      cap_data  <= rd_en_q ? rd_data : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [D_W:0] lane_in;
    assign lane_in = {cap_valid, cap_data[lane_hi(i, D_W):lane_lo(i, D_W)]};

    if (i == 0) begin : g_direct
      assign lane_out[i] = lane_in;
    end else begin : g_delay
      pipe #(
        .D_W  (D_W + 1),
        .pipes(i)
      ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_data (lane_in),
        .out_data(lane_out[i])
      );
    end

    assign out_valid[i]                                 = lane_out[i][D_W];
    assign out_data[lane_hi(i, D_W):lane_lo(i, D_W)]    = lane_out[i][D_W-1:0];
  end

endmodule
